// File: rtl/draw_scheduler_if.sv
// -----------------------------------------------------------------------------
// draw_scheduler_if
// Bundles every non-clock signal exchanged between the frame scheduler, the
// shape drawers and the VGA adapter.
//   master : scheduler side. It receives enable, frame_tick, shape_active and
//            the drawer handshake/pixel inputs. It drives draw_start, the
//            vga_* pixel port, busy, frame_done and overrun_count.
//   slave  : environment side (the drawers, the VGA adapter and game control).
// -----------------------------------------------------------------------------
interface draw_scheduler_if #(
    parameter int N_SHAPES = 8,
    parameter int COORD_W  = 11
);
    logic                          enable;
    logic                          frame_tick;
    logic [N_SHAPES-1:0]           shape_active;
    logic [N_SHAPES-1:0]           draw_done;
    logic [N_SHAPES-1:0]           shape_plot;
    logic [N_SHAPES*COORD_W-1:0]   shape_x;
    logic [N_SHAPES*COORD_W-1:0]   shape_y;
    logic [N_SHAPES*3-1:0]         shape_colour;
    logic [N_SHAPES-1:0]           draw_start;
    logic                          vga_plot;
    logic [COORD_W-1:0]            vga_x;
    logic [COORD_W-1:0]            vga_y;
    logic [2:0]                    vga_colour;
    logic                          busy;
    logic                          frame_done;
    logic [7:0]                    overrun_count;

    modport master (
        input  enable, frame_tick, shape_active, draw_done, shape_plot,
               shape_x, shape_y, shape_colour,
        output draw_start, vga_plot, vga_x, vga_y, vga_colour,
               busy, frame_done, overrun_count
    );

    modport slave (
        output enable, frame_tick, shape_active, draw_done, shape_plot,
               shape_x, shape_y, shape_colour,
        input  draw_start, vga_plot, vga_x, vga_y, vga_colour,
               busy, frame_done, overrun_count
    );
endinterface

// File: rtl/draw_scheduler.sv
// -----------------------------------------------------------------------------
// draw_scheduler
// Frame-level owner of the single VGA write port. On each accepted frame tick
// it sweeps the screen with the background colour. It then grants the port to
// each active shape drawer in ascending ID order, using a start/done
// handshake, and ends by pulsing frame_done.
// Ports:
//   clock  : system clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : draw_scheduler_if.master carrying control, the drawer handshake,
//            the drawer pixel streams, the VGA pixel port and the status outputs
// -----------------------------------------------------------------------------
module draw_scheduler #(
    parameter int         N_SHAPES  = 8,
    parameter int         ID_W      = 3,
    parameter int         COORD_W   = 11,
    parameter int         SCREEN_W  = 160,
    parameter int         SCREEN_H  = 120,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic               clock,
    input  logic               resetn,
    draw_scheduler_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SCAN  = 3'd2,
        S_DRAW  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [COORD_W-1:0] CLX_MAX = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] CLY_MAX = COORD_W'(SCREEN_H - 1);
    localparam logic [ID_W-1:0]    ID_MAX  = ID_W'(N_SHAPES - 1);

    state_t                state_q, state_d;
    logic [ID_W-1:0]       idx_q, idx_d;
    logic [COORD_W-1:0]    clx_q, clx_d;
    logic [COORD_W-1:0]    cly_q, cly_d;
    logic [N_SHAPES-1:0]   draw_start_q, draw_start_d;
    logic [7:0]            ovr_q, ovr_d;
    logic                  busy_q, frame_done_q;

    // One-hot grant vector for drawer id
    function automatic logic [N_SHAPES-1:0] grant_mask(input logic [ID_W-1:0] id);
        logic [N_SHAPES-1:0] one;
        one = {{(N_SHAPES-1){1'b0}}, 1'b1};
        return one << id;
    endfunction

    // State, index, clear-counter and grant sequencing
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        clx_d        = clx_q;
        cly_d        = cly_q;
        draw_start_d = draw_start_q;
        if (!bus.enable) begin
            // Abort: drop everything back to a clean idle frame boundary
            state_d      = S_IDLE;
            idx_d        = {ID_W{1'b0}};
            clx_d        = {COORD_W{1'b0}};
            cly_d        = {COORD_W{1'b0}};
            draw_start_d = {N_SHAPES{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    clx_d = {COORD_W{1'b0}};
                    cly_d = {COORD_W{1'b0}};
                    if (bus.frame_tick) begin
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CLEAR: begin
                    if (clx_q == CLX_MAX) begin
                        clx_d = {COORD_W{1'b0}};
                        if (cly_q == CLY_MAX) begin
                            cly_d   = {COORD_W{1'b0}};
                            idx_d   = {ID_W{1'b0}};
                            state_d = S_SCAN;
                        end else begin
                            cly_d = cly_q + COORD_W'(1);
                        end
                    end else begin
                        clx_d = clx_q + COORD_W'(1);
                    end
                end
                S_SCAN: begin
                    if (bus.shape_active[idx_q]) begin
                        draw_start_d = grant_mask(idx_q);
                        state_d      = S_DRAW;
                    end else if (idx_q == ID_MAX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + ID_W'(1);
                    end
                end
                S_DRAW: begin
                    // Only the granted drawer's done flag matters
                    if (bus.draw_done[idx_q]) begin
                        draw_start_d = {N_SHAPES{1'b0}};
                        if (idx_q == ID_MAX) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + ID_W'(1);
                            state_d = S_SCAN;
                        end
                    end else begin
                        state_d = S_DRAW;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d      = S_IDLE;
                    idx_d        = {ID_W{1'b0}};
                    draw_start_d = {N_SHAPES{1'b0}};
                end
            endcase
        end
    end

    // Saturating count of ticks dropped while a frame is in flight
    always_comb begin
        ovr_d = ovr_q;
        if (bus.enable && bus.frame_tick && (state_q != S_IDLE) && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // Registered state and status outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            idx_q        <= {ID_W{1'b0}};
            clx_q        <= {COORD_W{1'b0}};
            cly_q        <= {COORD_W{1'b0}};
            draw_start_q <= {N_SHAPES{1'b0}};
            ovr_q        <= 8'd0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            clx_q        <= clx_d;
            cly_q        <= cly_d;
            draw_start_q <= draw_start_d;
            ovr_q        <= ovr_d;
            // Status flags track the state being entered, so they line up with state_q
            busy_q       <= (state_d != S_IDLE);
            frame_done_q <= (state_d == S_DONE);
        end
    end

    // VGA port mux: clear sweep, granted drawer pass-through, otherwise quiet
    always_comb begin
        bus.vga_plot   = 1'b0;
        bus.vga_x      = {COORD_W{1'b0}};
        bus.vga_y      = {COORD_W{1'b0}};
        bus.vga_colour = 3'b000;
        case (state_q)
            S_CLEAR: begin
                bus.vga_plot   = 1'b1;
                bus.vga_x      = clx_q;
                bus.vga_y      = cly_q;
                bus.vga_colour = BG_COLOUR;
            end
            S_DRAW: begin
                bus.vga_plot   = bus.shape_plot[idx_q];
                bus.vga_x      = bus.shape_x[int'(idx_q)*COORD_W +: COORD_W];
                bus.vga_y      = bus.shape_y[int'(idx_q)*COORD_W +: COORD_W];
                bus.vga_colour = bus.shape_colour[int'(idx_q)*3 +: 3];
            end
            default: begin
                bus.vga_plot   = 1'b0;
                bus.vga_x      = {COORD_W{1'b0}};
                bus.vga_y      = {COORD_W{1'b0}};
                bus.vga_colour = 3'b000;
            end
        endcase
    end

    assign bus.draw_start    = draw_start_q;
    assign bus.busy          = busy_q;
    assign bus.frame_done    = frame_done_q;
    assign bus.overrun_count = ovr_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// -----------------------------------------------------------------------------
// tb_draw_scheduler
// Directed bench for draw_scheduler with N_SHAPES=4, SCREEN_W=4 and SCREEN_H=2.
// The clear sweep is checked from a vector table. The grant, abort, reset,
// overrun and saturation scenarios are checked with hand-written sequences.
// Drawer i presents the fixed pixel x=16+i, y=32+i, colour=i+1.
// -----------------------------------------------------------------------------
module tb_draw_scheduler;
    localparam int         N   = 4;
    localparam int         IDW = 2;
    localparam int         CW  = 11;
    localparam int         SW  = 4;
    localparam int         SH  = 2;
    localparam logic [2:0] BG  = 3'b101;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    always #5 clock = ~clock;

    draw_scheduler_if #(.N_SHAPES(N), .COORD_W(CW)) bus();

    draw_scheduler #(
        .N_SHAPES(N), .ID_W(IDW), .COORD_W(CW),
        .SCREEN_W(SW), .SCREEN_H(SH), .BG_COLOUR(BG)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus.master)
    );

    typedef struct {
        logic       tick;
        logic       plot;
        int         x;
        int         y;
        logic [2:0] col;
        logic       busy;
        logic       fd;
    } vec_t;

    vec_t         tv[14];
    int           total = 0;
    int           bad   = 0;
    int           cnt[N];
    logic         drawer_en;
    logic [N-1:0] stray_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock; then the drawer model reacts to the grants: the granted drawer raises done on its third granted cycle
    task automatic step();
        logic [N-1:0] d;
        @(posedge clock);
        #1;
        d = stray_done;
        for (int i = 0; i < N; i++) begin
            if (bus.draw_start[i]) cnt[i] = cnt[i] + 1;
            else                   cnt[i] = 0;
            if (drawer_en && cnt[i] >= 3) d[i] = 1'b1;
        end
        bus.draw_done = d;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ds;
        int exp_x;
        int waited;

        // Clear-sweep expectations: 8 background pixels, 4 scan cycles, DONE, IDLE
        for (int r = 0; r < 8; r++) tv[r] = '{(r == 3), 1'b1, r % 4, r / 4, BG, 1'b1, 1'b0};
        for (int r = 8; r < 12; r++) tv[r] = '{1'b0, 1'b0, 0, 0, 3'b000, 1'b1, 1'b0};
        tv[12] = '{1'b1, 1'b0, 0, 0, 3'b000, 1'b1, 1'b1};
        tv[13] = '{1'b0, 1'b0, 0, 0, 3'b000, 1'b0, 1'b0};

        bus.enable       = 1'b1;
        bus.frame_tick   = 1'b0;
        bus.shape_active = '0;
        bus.draw_done    = '0;
        bus.shape_plot   = '1;
        for (int i = 0; i < N; i++) begin
            bus.shape_x[i*CW +: CW]    = CW'(16 + i);
            bus.shape_y[i*CW +: CW]    = CW'(32 + i);
            bus.shape_colour[i*3 +: 3] = 3'(i + 1);
            cnt[i] = 0;
        end
        drawer_en  = 1'b1;
        stray_done = '0;

        // Reset values
        #1;
        chk("rst_ds",   32'(bus.draw_start), 32'd0);
        chk("rst_plot", 32'(bus.vga_plot), 32'd0);
        chk("rst_x",    32'(bus.vga_x), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_fd",   32'(bus.frame_done), 32'd0);
        chk("rst_ovr",  32'(bus.overrun_count), 32'd0);
        #20 resetn = 1'b1;
        step();
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // Clear sweep with shape_active=0000; extra ticks in CLEAR and in DONE count as overruns
        bus.frame_tick = 1'b1;
        for (int r = 0; r < 14; r++) begin
            step();
            chk($sformatf("clr%0d_plot", r), 32'(bus.vga_plot), 32'(tv[r].plot));
            chk($sformatf("clr%0d_x", r),    32'(bus.vga_x), 32'(tv[r].x));
            chk($sformatf("clr%0d_y", r),    32'(bus.vga_y), 32'(tv[r].y));
            chk($sformatf("clr%0d_col", r),  32'(bus.vga_colour), 32'(tv[r].col));
            chk($sformatf("clr%0d_busy", r), 32'(bus.busy), 32'(tv[r].busy));
            chk($sformatf("clr%0d_fd", r),   32'(bus.frame_done), 32'(tv[r].fd));
            bus.frame_tick = tv[r].tick;
        end
        chk("clr_ovr", 32'(bus.overrun_count), 32'd2);

        // Sparse grant 1010; stray done on inactive shapes 0 and 2 must be ignored
        stray_done       = 4'b0101;
        bus.shape_active = 4'b1010;
        bus.frame_tick   = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            bus.frame_tick = 1'b0;
            exp_ds = (c >= 11 && c <= 13) ? 2 : (c >= 16 && c <= 18) ? 8 : 0;
            exp_x  = (c >= 11 && c <= 13) ? 17 : (c >= 16 && c <= 18) ? 19 : 0;
            chk($sformatf("sp%0d_ds", c), 32'(bus.draw_start), 32'(exp_ds));
            chk($sformatf("sp%0d_fd", c), 32'(bus.frame_done), 32'(c == 19));
            if (c >= 9) begin
                chk($sformatf("sp%0d_plot", c), 32'(bus.vga_plot), 32'(exp_ds != 0));
                chk($sformatf("sp%0d_x", c),    32'(bus.vga_x), 32'(exp_x));
            end
        end
        chk("sp_busy_end", 32'(bus.busy), 32'd0);
        chk("sp_col", 32'(bus.vga_colour), 32'd0);
        stray_done = '0;

        // Abort: enable drops while shape 2 holds the grant
        bus.shape_active = 4'b0100;
        drawer_en        = 1'b0;
        bus.frame_tick   = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            bus.frame_tick = 1'b0;
        end
        chk("ab_ds_before", 32'(bus.draw_start), 32'd4);
        chk("ab_col", 32'(bus.vga_colour), 32'd3);
        bus.enable     = 1'b0;
        bus.frame_tick = 1'b1;
        step();
        chk("ab_ds",   32'(bus.draw_start), 32'd0);
        chk("ab_busy", 32'(bus.busy), 32'd0);
        chk("ab_fd",   32'(bus.frame_done), 32'd0);
        step();
        chk("ab_fd2",  32'(bus.frame_done), 32'd0);
        chk("ab_ovr",  32'(bus.overrun_count), 32'd2);
        bus.frame_tick = 1'b0;
        bus.enable     = 1'b1;
        step();

        // Asynchronous reset in the middle of a DRAW grant
        bus.frame_tick = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            bus.frame_tick = 1'b0;
        end
        chk("rd_ds_before", 32'(bus.draw_start), 32'd4);
        resetn = 1'b0;
        #1;
        chk("rd_ds",   32'(bus.draw_start), 32'd0);
        chk("rd_busy", 32'(bus.busy), 32'd0);
        chk("rd_plot", 32'(bus.vga_plot), 32'd0);
        chk("rd_x",    32'(bus.vga_x), 32'd0);
        chk("rd_ovr",  32'(bus.overrun_count), 32'd0);
        #1 resetn = 1'b1;
        step();
        chk("rd_idle", 32'(bus.busy), 32'd0);
        bus.shape_active = 4'b0000;
        bus.frame_tick   = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        chk("rd_plot1", 32'(bus.vga_plot), 32'd1);
        chk("rd_col1",  32'(bus.vga_colour), 32'(BG));
        chk("rd_busy1", 32'(bus.busy), 32'd1);

        // Overrun: three ticks during CLEAR, then a tick in IDLE starts a frame uncounted
        for (int k = 0; k < 3; k++) begin
            bus.frame_tick = 1'b1;
            step();
            bus.frame_tick = 1'b0;
            step();
        end
        waited = 0;
        while (bus.busy && waited < 40) begin
            step();
            waited++;
        end
        chk("ov_idle_wait", 32'(bus.busy), 32'd0);
        chk("ov_cnt", 32'(bus.overrun_count), 32'd3);
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        chk("ov_start", 32'(bus.busy), 32'd1);
        chk("ov_cnt2",  32'(bus.overrun_count), 32'd3);
        waited = 0;
        while (bus.busy && waited < 40) begin
            step();
            waited++;
        end
        chk("ov_idle_wait2", 32'(bus.busy), 32'd0);

        // Saturation: tick held high for 300 cycles while shape 0 never finishes
        bus.shape_active = 4'b0001;
        drawer_en        = 1'b0;
        bus.frame_tick   = 1'b1;
        for (int c = 0; c < 300; c++) step();
        chk("sat_cnt",  32'(bus.overrun_count), 32'd255);
        chk("sat_ds",   32'(bus.draw_start), 32'd1);
        bus.frame_tick = 1'b0;
        bus.enable     = 1'b0;
        step();
        chk("sat_hold", 32'(bus.overrun_count), 32'd255);
        chk("sat_busy", 32'(bus.busy), 32'd0);
        bus.enable = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
